// File: rtl/ldpc_pkg.sv
// rtl/ldpc_pkg.sv - shared types, default parity-check matrix and helpers for the bit-flip LDPC decoder
package ldpc_pkg;

    localparam int H_MAX_BITS = 4096;
    localparam int POP_W      = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_e;

    // Check i covers bits i, M+i and M+((i+1) mod M): systematic part of weight 1, parity part of weight 2.
    function automatic logic [H_MAX_BITS-1:0] default_h(input int n, input int m);
        logic [H_MAX_BITS-1:0] h;
        h = '0;
        for (int i = 0; i < m; i++) begin
            h[i*n + i]                 = 1'b1;
            h[i*n + m + i]             = 1'b1;
            h[i*n + m + ((i + 1) % m)] = 1'b1;
        end
        return h;
    endfunction

    function automatic int popcount(input logic [POP_W-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < POP_W; i++) begin
            c = c + int'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/ldpc_bf_decoder_syndrome.sv
// rtl/ldpc_bf_decoder_syndrome.sv - combinational syndrome and majority flip vector from the current codeword
module ldpc_syndrome_calc
    import ldpc_pkg::*;
#(
    parameter int N        = 16,
    parameter int M        = 8,
    parameter     H_MATRIX = default_h(N, M)
) (
    input  logic [N-1:0] cw_i,
    output logic [M-1:0] syn_o,
    output logic [N-1:0] flip_o
);

    localparam int CNT_W = $clog2(M + 1);

    logic [M-1:0]     col_h;
    logic [M-1:0]     col_s;
    logic [CNT_W-1:0] unsat;
    logic [CNT_W-1:0] deg;

    always_comb begin
        syn_o = '0;
        for (int m = 0; m < M; m++) begin
            for (int n = 0; n < N; n++) begin
                syn_o[m] = syn_o[m] ^ (H_MATRIX[m*N + n] & cw_i[n]);
            end
        end
    end

    // A bit flips when strictly more than half of its checks are unsatisfied.
    always_comb begin
        flip_o = '0;
        col_h  = '0;
        col_s  = '0;
        unsat  = '0;
        deg    = '0;
        for (int n = 0; n < N; n++) begin
            for (int m = 0; m < M; m++) begin
                col_h[m] = H_MATRIX[m*N + n];
            end
            col_s     = col_h & syn_o;
            unsat     = CNT_W'(popcount(POP_W'(col_s)));
            deg       = CNT_W'(popcount(POP_W'(col_h)));
            flip_o[n] = (deg != '0) && ({unsat, 1'b0} > {1'b0, deg});
        end
    end

endmodule

// File: rtl/ldpc_bf_decoder.sv
// rtl/ldpc_bf_decoder.sv - hard-decision bit-flip LDPC decoder top; LDPC_STATS_EN adds block/fail counters
module ldpc_bf_decoder
    import ldpc_pkg::*;
#(
    parameter int N        = 16,
    parameter int M        = 8,
    parameter int MAX_ITER = 8,
    parameter     H_MATRIX = default_h(N, M),
    parameter int ITER_W   = $clog2(MAX_ITER + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_data,
    output logic              out_pass,
    output logic [ITER_W-1:0] out_iter
`ifdef LDPC_STATS_EN
    ,
    output logic [15:0]       stat_blocks,
    output logic [15:0]       stat_fails
`endif
);

    state_e              state_q, state_d;
    logic [N-1:0]        cw_q, cw_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [N-1:0]        data_q, data_d;
    logic                pass_q, pass_d;
    logic [ITER_W-1:0]   oiter_q, oiter_d;
    logic                valid_q, valid_d;
    logic [M-1:0]        syn;
    logic [N-1:0]        flip;
    logic                out_hs;

    ldpc_syndrome_calc #(
        .N        (N),
        .M        (M),
        .H_MATRIX (H_MATRIX)
    ) u_syndrome (
        .cw_i   (cw_q),
        .syn_o  (syn),
        .flip_o (flip)
    );

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_pass  = pass_q;
    assign out_iter  = oiter_q;
    assign out_hs    = valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        cw_d    = cw_q;
        iter_d  = iter_q;
        data_d  = data_q;
        pass_d  = pass_q;
        oiter_d = oiter_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    cw_d    = in_data;
                    iter_d  = '0;
                    state_d = ITER;
                end
            end
            ITER: begin
                if (syn == '0 || iter_q == ITER_W'(MAX_ITER) || flip == '0) begin
                    state_d = DONE;
                    data_d  = cw_q;
                    pass_d  = (syn == '0);
                    oiter_d = iter_q;
                end else begin
                    cw_d   = cw_q ^ flip;
                    iter_d = iter_q + ITER_W'(1);
                end
            end
            DONE: begin
                // Result registers load on entry; out_valid follows one cycle later.
                if (out_hs) begin
                    state_d = IDLE;
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cw_q    <= '0;
            iter_q  <= '0;
            data_q  <= '0;
            pass_q  <= 1'b0;
            oiter_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cw_q    <= cw_d;
            iter_q  <= iter_d;
            data_q  <= data_d;
            pass_q  <= pass_d;
            oiter_q <= oiter_d;
            valid_q <= valid_d;
        end
    end

`ifdef LDPC_STATS_EN
    logic [15:0] blocks_q;
    logic [15:0] fails_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            blocks_q <= '0;
            fails_q  <= '0;
        end else if (out_hs) begin
            if (blocks_q != 16'hFFFF) begin
                blocks_q <= blocks_q + 16'd1;
            end
            if (!pass_q && fails_q != 16'hFFFF) begin
                fails_q <= fails_q + 16'd1;
            end
        end
    end

    assign stat_blocks = blocks_q;
    assign stat_fails  = fails_q;
`endif

endmodule

// File: tb/tb_ldpc_bf_decoder.sv
// tb/tb_ldpc_bf_decoder.sv - self-checking bench for ldpc_bf_decoder against a set-based decoding model
module tb_ldpc_bf_decoder;

    localparam int N    = 16;
    localparam int M    = 8;
    localparam int MAXI = 8;
    localparam int IW   = 4;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [N-1:0]  in_data   = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N-1:0]  out_data;
    logic          out_pass;
    logic [IW-1:0] out_iter;
`ifdef LDPC_STATS_EN
    logic [15:0]   stat_blocks;
    logic [15:0]   stat_fails;
`endif

    int          total = 0;
    int          bad   = 0;
    logic        exp_live = 1'b0;
    logic [15:0] exp_data = '0;
    logic        exp_pass = 1'b0;
    int          exp_iter = 0;

    always #5 clk = ~clk;

    ldpc_bf_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_pass  (out_pass),
        .out_iter  (out_iter)
`ifdef LDPC_STATS_EN
        ,
        .stat_blocks (stat_blocks),
        .stat_fails  (stat_fails)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic bit covers(input int m, input int n);
        return (n == m) || (n == M + m) || (n == M + ((m + 1) % M));
    endfunction

    // Decode by the rules directly: evaluate checks as sets, count votes per bit, flip the majority set.
    function automatic void model(input logic [15:0] w, output logic [15:0] d,
                                  output logic p, output int it);
        logic [15:0] c;
        logic [15:0] f;
        int          s [M];
        int          u;
        int          dg;
        bit          anys;
        bit          done;
        c    = w;
        it   = 0;
        p    = 1'b0;
        done = 1'b0;
        for (int k = 0; k <= MAXI + 1 && !done; k++) begin
            anys = 1'b0;
            for (int m = 0; m < M; m++) begin
                s[m] = 0;
                for (int n = 0; n < N; n++) begin
                    if (covers(m, n) && c[n]) s[m] = s[m] ^ 1;
                end
                if (s[m] != 0) anys = 1'b1;
            end
            if (!anys) begin
                p    = 1'b1;
                done = 1'b1;
            end else if (it == MAXI) begin
                done = 1'b1;
            end else begin
                f = '0;
                for (int n = 0; n < N; n++) begin
                    u  = 0;
                    dg = 0;
                    for (int m = 0; m < M; m++) begin
                        if (covers(m, n)) begin
                            dg++;
                            if (s[m] != 0) u++;
                        end
                    end
                    if (2 * u > dg) f[n] = 1'b1;
                end
                if (f == '0) begin
                    done = 1'b1;
                end else begin
                    c  = c ^ f;
                    it = it + 1;
                end
            end
        end
        d = c;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            chk("out_expected", 32'(exp_live), 32'(1));
            chk("out_data", 32'(out_data), 32'(exp_data));
            chk("out_pass", 32'(out_pass), 32'(exp_pass));
            chk("out_iter", 32'(out_iter), 32'(exp_iter));
            chk("in_ready_busy", 32'(in_ready), 32'(0));
        end
    end

    task automatic run_block(input logic [15:0] w, input int stall, input bit early);
        logic [15:0] ed;
        logic        ep;
        int          ei;
        int          n;
        int          lat;
        model(w, ed, ep, ei);
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_idle", 32'(in_ready), 32'(1));
        in_valid = 1'b1;
        in_data  = w;
        if (early) out_ready = 1'b1;
        @(posedge clk);
        exp_data = ed;
        exp_pass = ep;
        exp_iter = ei;
        exp_live = 1'b1;
        #1;
        in_valid = 1'b0;
        in_data  = '0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
        end
        chk("latency", 32'(lat), 32'(2 + ei));
        repeat (stall) @(posedge clk);
        #1;
        chk("valid_held", 32'(out_valid), 32'(1));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        exp_live  = 1'b0;
        chk("valid_drop", 32'(out_valid), 32'(0));
    endtask

    initial begin
        logic [15:0] md;
        logic        mp;
        int          mi;
        bit          seen;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        chk("rst_out_data", 32'(out_data), 32'(0));
        chk("rst_out_pass", 32'(out_pass), 32'(0));
        chk("rst_out_iter", 32'(out_iter), 32'(0));
        rst = 1'b0;

        model(16'h0008, md, mp, mi);
        chk("model_0008_data", 32'(md), 32'h0000);
        chk("model_0008_pass", 32'(mp), 32'(1));
        chk("model_0008_iter", 32'(mi), 32'(1));
        model(16'h0800, md, mp, mi);
        chk("model_0800_data", 32'(md), 32'h0800);
        chk("model_0800_pass", 32'(mp), 32'(0));
        chk("model_0800_iter", 32'(mi), 32'(8));
        model(16'hFFFF, md, mp, mi);
        chk("model_ffff_data", 32'(md), 32'h0000);
        chk("model_ffff_iter", 32'(mi), 32'(1));
        model(16'hFF00, md, mp, mi);
        chk("model_ff00_data", 32'(md), 32'hFF00);
        chk("model_ff00_iter", 32'(mi), 32'(0));

        run_block(16'h0000, 0, 1'b0);
        run_block(16'hFF00, 5, 1'b0);
        run_block(16'h0008, 0, 1'b0);
        run_block(16'hFFFF, 0, 1'b0);
        run_block(16'h0800, 0, 1'b0);
`ifdef LDPC_STATS_EN
        chk("stat_blocks", 32'(stat_blocks), 32'(5));
        chk("stat_fails", 32'(stat_fails), 32'(1));
`endif

        @(negedge clk);
        chk("in_ready_pre_abort", 32'(in_ready), 32'(1));
        in_valid = 1'b1;
        in_data  = 16'h0800;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'(0));
        chk("abort_out_valid", 32'(out_valid), 32'(0));
        rst  = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_output", 32'(seen), 32'(0));

        run_block(16'h0008, 0, 1'b1);
        run_block(16'h0100, 2, 1'b0);
        run_block(16'h0300, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
